// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Covers the op codes, the controller states and the default divide latency.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } state_e;

    localparam int DEF_WIDTH = 32;
    // One restoring iteration per operand bit, plus the sign-fix cycle.
    localparam int DIV_LAT   = DEF_WIDTH + 1;

    function automatic int div_lat(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per step.
// finished rises once WIDTH steps have run since the last load.
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             finished
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    it_cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             take;

    // Partial remainder shifted left needs one extra bit before the trial subtract.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign take    = (shifted >= {1'b0, dsr_q});
    assign diff    = shifted - {1'b0, dsr_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            it_cnt <= '0;
        end else if (load) begin
            it_cnt <= '0;
        end else if (step) begin
            it_cnt <= it_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
        end else if (step) begin
            rem_q <= take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], take};
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign finished  = (it_cnt == CW'(WIDTH));

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// HI/LO change only on MTHI/MTLO acceptance or on the single completion edge.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    mul_cnt_q;
    logic             acc_mul, acc_div, wr_hi, wr_lo;
    logic             mul_fin, div_fin, div_step;
    logic             op_signed;

    logic signed [WIDTH:0] mul_a_p0, mul_b_p0;
    logic signed [PW-1:0]  mul_prod;
    logic [WIDTH-1:0]      div_a_p0;
    logic                  q_neg_p0, r_neg_p0, dz_p0;

    logic [WIDTH-1:0] quo, rem;
    logic             div_finished;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign op_signed = ~op[0];

    mdu_div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (acc_div),
        .step      (div_step),
        .dividend  (magnitude(A, op_signed)),
        .divisor   (magnitude(B, op_signed)),
        .quotient  (quo),
        .remainder (rem),
        .finished  (div_finished)
    );

    always_comb begin
        state_d  = state_q;
        acc_mul  = 1'b0;
        acc_div  = 1'b0;
        wr_hi    = 1'b0;
        wr_lo    = 1'b0;
        mul_fin  = 1'b0;
        div_fin  = 1'b0;
        div_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            acc_mul = 1'b1;
                            state_d = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            acc_div = 1'b1;
                            state_d = ST_DIV;
                        end
                        OP_MTHI: wr_hi = 1'b1;
                        OP_MTLO: wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (mul_cnt_q == MUL_LAST) begin
                    mul_fin = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (div_finished) begin
                    div_fin = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    div_step = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands sign-extended by one bit so MULTU and MULT share the signed multiplier.
    assign mul_prod = PW'(mul_a_p0) * PW'(mul_b_p0);

    // Stage p0: operands and sign bookkeeping captured at acceptance.
    always_ff @(posedge clk) begin
        if (acc_mul) begin
            mul_a_p0 <= {op_signed & A[WIDTH-1], A};
            mul_b_p0 <= {op_signed & B[WIDTH-1], B};
        end
        if (acc_div) begin
            div_a_p0 <= A;
            q_neg_p0 <= op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg_p0 <= op_signed & A[WIDTH-1];
            dz_p0    <= (B == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mul_cnt_q <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != ST_IDLE);
            done    <= mul_fin | div_fin;
            if (acc_mul) begin
                mul_cnt_q <= '0;
            end else if (state_q == ST_MUL) begin
                mul_cnt_q <= mul_cnt_q + 1'b1;
            end
            if (wr_hi) hi <= A;
            if (wr_lo) lo <= A;
            if (mul_fin) begin
                hi <= mul_prod[PW-1:WIDTH];
                lo <= mul_prod[WIDTH-1:0];
            end
            // Divide by zero returns the untouched dividend, not its magnitude.
            if (div_fin) begin
                if (dz_p0) begin
                    hi <= div_a_p0;
                    lo <= '1;
                end else begin
                    hi <= apply_sign(rem, r_neg_p0);
                    lo <= apply_sign(quo, q_neg_p0);
                end
            end
        end
    end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers.
- Successor to the combinational datapath ALU: adds MULT/MULTU/DIV/DIVU/MTHI/MTLO with a busy/done handshake.
- Sits in the EX stage beside the ALU. The pipeline control stalls on busy before MFHI/MFLO or a new MDU op.

Parameters:
WIDTH, 32, operand and HI/LO width (even, >=4)
MUL_LAT, 5, cycles busy for multiply (>=1)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request; accepted only when busy=0
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
A  in  WIDTH  rs operand (dividend/multiplicand; MTHI/MTLO source)
B  in  WIDTH  rt operand (divisor/multiplier)
flush  in  1  abort in-flight op (exception/branch squash)
busy  out  1  operation in flight
done  out  1  one-cycle pulse; HI/LO updated on the same edge
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Any in-flight op is lost.
- States: IDLE, MUL, DIV. Only IDLE accepts start.
- start while busy=1: ignored, no effect, no queuing.
- start with op=11x: ignored.
- MTHI/MTLO (start=1, IDLE): hi<=A or lo<=A at that edge.
  - busy stays 0, done stays 0.
  - The other register is unchanged.
- MULT/MULTU accepted at edge k:
  - Operands are latched; the 2*WIDTH product is formed (signed for MULT, zero-extended for MULTU). A registered multiply is acceptable.
  - busy=1 after edge k through edge k+MUL_LAT.
  - At edge k+MUL_LAT: {hi,lo}<=product, busy<=0, done<=1 for one cycle.
- DIV/DIVU accepted at edge k:
  - Operands are latched as magnitudes (signed ops take absolute value; result signs are recorded).
  - WIDTH restoring iterations, one per cycle, then one sign-fix cycle: total latency WIDTH+1.
  - At edge k+WIDTH+1: lo<=quotient, hi<=remainder, busy<=0, done<=1.
- Signed division semantics:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Overflow case (min_int / -1): lo=min_int, hi=0. This falls out of the magnitude algorithm; no special case is added.
- Divide by zero (B=0, signed or unsigned):
  - Full latency is still taken.
  - lo=all ones, hi=A (original dividend, unmodified).
- HI/LO hold their previous values for the whole busy period, so a stalled reader never sees partial results.
- flush=1:
  - Cancels any in-flight MUL/DIV: next state IDLE, busy<=0, done=0, hi/lo unchanged.
  - flush together with start in IDLE: start is ignored, including MTHI/MTLO.
  - flush on the completion edge: completion is suppressed (flush has priority).
- done and the completion update never coincide with acceptance of a new op. IDLE is re-entered first, so back-to-back ops are spaced by at least one cycle.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package mdu_pkg:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO)
  - state enum (ST_IDLE, ST_MUL, ST_DIV)
  - DIV_LAT = WIDTH+1
- One sub-module, mdu_div_core: iterative unsigned restoring divider (load, step, remainder/quotient registers, iteration counter). Parent mdu_hilo owns sign handling, multiply, HI/LO, the FSM and flush.

Test Plan:
- Reset then MTLO A=0x12345678 -> lo=0x12345678 next edge, hi=0, busy never asserted.
- MULT A=0xFFFFFFFE (-2), B=0x00000003:
  - busy high exactly 5 cycles
  - done pulse
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA
- MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2:
  - busy 33 cycles
  - lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1)
- DIVU A=100, B=0:
  - lo=0xFFFFFFFF, hi=100
- DIV A=0x80000000, B=0xFFFFFFFF:
  - lo=0x80000000, hi=0
- DIV started, flush at cycle 10 -> busy drops next edge, no done, hi/lo keep prior values.
- DIV started, start re-pulsed mid-op -> ignored.
- reset asserted mid-op -> hi=lo=0, busy=0 immediately (async).
